// File: rtl/morse_pattern_player.sv
// morse_pattern_player
//   Plays up to four Morse symbols (dot = 1 unit on, dash = 3 units on) from a
//   latched 4-bit pattern, MSB first. Symbols are separated by a 1-unit gap,
//   and the pattern ends with a 3-unit letter gap and a one-cycle done pulse.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    play request, honoured only while idle
//   pattern  symbol bits (1 = dash, 0 = dot), bit 3 is played first
//   len      number of symbols (0..7, values above 4 are treated as 4)
//   led      registered Morse output (1 = on)
//   busy     high while a pattern is playing (ON/GAP/LGAP)
//   done     one-cycle pulse when playback completes
//   sym_idx  index of the symbol playing or just played (0 = pattern[3])
module morse_pattern_player #(
  parameter int UNIT_TICKS = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] pattern,
  input  logic [2:0] len,
  output logic       led,
  output logic       busy,
  output logic       done,
  output logic [1:0] sym_idx
);

  localparam int TW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(UNIT_TICKS - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ON   = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] LGAP = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]    state_r;
  logic [3:0]    pattern_r;
  logic [2:0]    len_r;
  logic [1:0]    sym_idx_r;
  logic [TW-1:0] tick_r;
  logic [1:0]    unit_r;   // remaining whole units after the current one
  logic          led_r;
  logic          busy_r;
  logic          done_r;

  logic [2:0] next_state_s;
  logic [1:0] next_units_s;
  logic       unit_end_s;
  logic       expire_s;
  logic       last_sym_s;
  logic [1:0] next_idx_s;
  logic       next_bit_s;
  logic       timed_s;

  // Timing and sequencing decode shared by the next-state logic.
  always_comb begin
    unit_end_s = (tick_r == TICK_MAX);
    expire_s   = unit_end_s && (unit_r == 2'd0);
    last_sym_s = ({1'b0, sym_idx_r} == (len_r - 3'd1));
    next_idx_s = sym_idx_r + 2'd1;
    // Bit of the symbol that follows the current gap.
    next_bit_s = pattern_r[2'd3 - next_idx_s];
    timed_s    = (state_r == ON) || (state_r == GAP) || (state_r == LGAP);
  end

  // Next-state logic; next_units_s is the unit count loaded on a state change.
  always_comb begin
    next_state_s = state_r;
    next_units_s = 2'd0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len == 3'd0) begin
            next_state_s = DONE;
          end else begin
            next_state_s = ON;
            // First symbol comes straight from the input being latched.
            next_units_s = pattern[3] ? 2'd2 : 2'd0;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ON: begin
        if (expire_s) begin
          if (last_sym_s) begin
            next_state_s = LGAP;
            next_units_s = 2'd2;
          end else begin
            next_state_s = GAP;
          end
        end else begin
          next_state_s = ON;
        end
      end
      GAP: begin
        if (expire_s) begin
          next_state_s = ON;
          next_units_s = next_bit_s ? 2'd2 : 2'd0;
        end else begin
          next_state_s = GAP;
        end
      end
      LGAP: begin
        if (expire_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = LGAP;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, latched pattern, symbol index and unit timing counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pattern_r <= 4'd0;
      len_r     <= 3'd0;
      sym_idx_r <= 2'd0;
      tick_r    <= '0;
      unit_r    <= 2'd0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == IDLE) && start) begin
        pattern_r <= pattern;
        len_r     <= (len > 3'd4) ? 3'd4 : len;
        sym_idx_r <= 2'd0;
      end else if ((state_r == GAP) && expire_s) begin
        sym_idx_r <= next_idx_s;
      end
      // Counters restart on every state change so no error accumulates.
      if (next_state_s != state_r) begin
        tick_r <= '0;
        unit_r <= next_units_s;
      end else if (timed_s) begin
        if (unit_end_s) begin
          tick_r <= '0;
          unit_r <= unit_r - 2'd1;
        end else begin
          tick_r <= tick_r + 1'b1;
        end
      end else begin
        tick_r <= '0;
        unit_r <= 2'd0;
      end
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      led_r  <= (next_state_s == ON);
      busy_r <= (next_state_s == ON) || (next_state_s == GAP) || (next_state_s == LGAP);
      done_r <= (next_state_s == DONE);
    end
  end

  assign led     = led_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign sym_idx = sym_idx_r;

endmodule

// File: tb/tb_morse_pattern_player.sv
// Directed bench for morse_pattern_player with UNIT_TICKS = 4.
module tb_morse_pattern_player;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] pattern;
  logic [2:0] len;
  logic       led;
  logic       busy;
  logic       done;
  logic [1:0] sym_idx;

  int n_checks;
  int n_fail;
  int seg[8];
  int nseg;

  morse_pattern_player #(.UNIT_TICKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .len(len),
    .led(led), .busy(busy), .done(done), .sym_idx(sym_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected waveform is held in seg[0..nseg-1]: alternating on/off run
  // lengths starting with on; segment si belongs to symbol si/2.
  task automatic play(input string tag, input logic [3:0] pat, input logic [2:0] ln,
                      input int exp_idx, input bit disturb);
    int total, k, done_at, led_bad, busy_bad, idx_bad, acc;
    logic exp_led;
    int exp_sym;
    total = 0;
    for (int i = 0; i < nseg; i++) total += seg[i];
    pattern = pat;
    len = ln;
    start = 1'b1;
    cycle();
    start = 1'b0;
    done_at = -1; led_bad = 0; busy_bad = 0; idx_bad = 0; k = 0;
    while (done_at < 0 && k < 300) begin
      if (done) begin
        done_at = k;
      end else begin
        acc = 0; exp_led = 1'b0; exp_sym = 0;
        for (int si = 0; si < nseg; si++) begin
          if (k >= acc && k < acc + seg[si]) begin
            exp_led = (si % 2 == 0);
            exp_sym = si / 2;
          end
          acc += seg[si];
        end
        if (led !== exp_led) led_bad++;
        if (busy !== 1'b1) busy_bad++;
        if (int'(sym_idx) != exp_sym) idx_bad++;
        if (disturb && k == 10) begin start = 1'b1; pattern = 4'b0101; len = 3'd2; end
        if (disturb && k == 11) start = 1'b0;
        cycle();
        k++;
      end
    end
    check($sformatf("%s_done_cycle", tag), done_at, total);
    check($sformatf("%s_led_bad_cycles", tag), led_bad, 0);
    check($sformatf("%s_busy_bad_cycles", tag), busy_bad, 0);
    check($sformatf("%s_symidx_bad_cycles", tag), idx_bad, 0);
    check($sformatf("%s_led_at_done", tag), int'(led), 0);
    check($sformatf("%s_busy_at_done", tag), int'(busy), 0);
    check($sformatf("%s_symidx_at_done", tag), int'(sym_idx), exp_idx);
    cycle();
    check($sformatf("%s_done_one_cycle", tag), int'(done), 0);
    cycle();
  endtask

  initial begin
    int n, hits;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; pattern = 4'd0; len = 3'd0;
    cycle(); cycle();
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_symidx", int'(sym_idx), 0);
    rst_n = 1'b1;
    cycle(); cycle();

    // dash dot dash dot
    seg = '{12, 4, 4, 4, 12, 4, 4, 12}; nseg = 8;
    play("p1010", 4'b1010, 3'd4, 3, 1'b0);

    // single dot
    seg = '{4, 12, 0, 0, 0, 0, 0, 0}; nseg = 2;
    play("p0000_l1", 4'b0000, 3'd1, 0, 1'b0);

    // zero length: straight to done
    nseg = 0;
    play("len0", 4'b1111, 3'd0, 0, 1'b0);

    // length clamp: four dashes
    seg = '{12, 4, 12, 4, 12, 4, 12, 12}; nseg = 8;
    play("len7", 4'b1111, 3'd7, 3, 1'b0);
    play("len4", 4'b1111, 3'd4, 3, 1'b0);

    // start and inputs changed mid-playback are ignored
    seg = '{12, 4, 4, 4, 12, 4, 4, 12}; nseg = 8;
    play("ignore_start", 4'b1010, 3'd4, 3, 1'b1);

    // async reset during the second symbol
    pattern = 4'b1010; len = 3'd4; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 17; i++) cycle();
    check("mid_led_before_rst", int'(led), 1);
    check("mid_symidx_before_rst", int'(sym_idx), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_led", int'(led), 0);
    check("async_busy", int'(busy), 0);
    check("async_symidx", int'(sym_idx), 0);
    hits = 0;
    cycle(); if (done) hits++;
    cycle(); if (done) hits++;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (done) hits++;
    end
    check("no_done_after_abort", hits, 0);
    check("idle_after_abort", int'(busy), 0);
    play("replay", 4'b1010, 3'd4, 3, 1'b0);

    // start held high: back-to-back playbacks with one idle cycle
    pattern = 4'b0000; len = 3'd1; start = 1'b1;
    cycle();
    check("rep_rise0", int'(led), 1);
    n = 0;
    while (!done && n < 40) begin cycle(); n++; end
    check("rep_len0", n, 16);
    cycle();
    check("rep_idle_led", int'(led), 0);
    check("rep_idle_busy", int'(busy), 0);
    check("rep_idle_done", int'(done), 0);
    cycle();
    check("rep_rise1", int'(led), 1);
    n = 0;
    while (!done && n < 40) begin cycle(); n++; end
    check("rep_len1", n, 16);
    start = 1'b0;
    cycle(); cycle();
    check("rep_stop", int'(led), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
